// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants and the controller state type for the sequential
// single-precision add/subtract unit.
//   BIAS, EXP_W, MAN_W, EXP_MAX : IEEE-754 single-precision field geometry
//   QNAN                        : canonical quiet NaN returned for invalid ops
//   POS_INF                     : +infinity; OR in a sign bit for -infinity
//   state_t                     : controller states, also exported for debug
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_PACK   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/fp_addsub_seq_if.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq_if
// Operand and result handshake bundle of fp_addsub_seq.
//   in_valid / in_ready   : operand channel (A_in, B_in, A_S)
//   out_valid / out_ready : result channel (Result)
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid && ready are both high. A source that raises valid keeps
// it and its payload steady until that transfer; ready may be asserted
// independently of valid. The unit's in_ready is high only while idle, and
// its Result is held unchanged for as long as out_valid is high.
//   master : producer/consumer side (testbench or system)
//   slave  : the add/subtract unit
// ---------------------------------------------------------------------------
interface fp_addsub_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        A_S;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;

    modport master (
        output in_valid, A_in, B_in, A_S, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, A_in, B_in, A_S, out_ready,
        output in_ready, out_valid, Result
    );

endinterface

// File: rtl/fp_unpack.sv
// ---------------------------------------------------------------------------
// fp_unpack
// Combinational field split and classification of one single-precision
// operand. Exponent-zero encodings (zero and subnormals) are reported as
// zero, so subnormals are flushed by the caller.
//   op      in  32  IEEE-754 single operand
//   sign    out 1   sign bit
//   exp     out 8   biased exponent
//   man     out 23  stored mantissa (no hidden bit)
//   is_zero out 1   exponent == 0
//   is_inf  out 1   exponent all ones, mantissa zero
//   is_nan  out 1   exponent all ones, mantissa non-zero
// ---------------------------------------------------------------------------
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]      op,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] man,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan
);

    logic exp_all_ones;

    assign sign         = op[31];
    assign exp          = op[30:23];
    assign man          = op[22:0];
    assign exp_all_ones = (exp == EXP_W'(EXP_MAX));
    assign is_zero      = (exp == '0);
    assign is_inf       = exp_all_ones && (man == '0);
    assign is_nan       = exp_all_ones && (man != '0);

endmodule

// File: rtl/fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq
// Multi-cycle single-precision add/subtract, round toward zero.
// Sequence: IDLE -> UNPACK -> [ALIGN] -> ADD -> [NORM] -> PACK -> DONE.
// Alignment and normalisation move one bit per cycle, so latency from the
// accept edge to out_valid is 3 + d + k cycles (2 for special operands).
//   clk       in  1   rising-edge clock
//   rst       in  1   asynchronous active-high reset
//   bus       slave   operand/result handshake bundle (fp_addsub_seq_if)
//   dbg_state out     current controller state
// ---------------------------------------------------------------------------
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXTRA_BITS = 3,
    parameter int MAX_ALIGN  = 26
)
(
    input  logic                 clk,
    input  logic                 rst,
    fp_addsub_seq_if.slave       bus,
    output state_t               dbg_state
);

    // Working significand: hidden bit at the top, mantissa, then guard bits.
    localparam int SIG_W = 25 + EXTRA_BITS;
    localparam int GRD_W = SIG_W - 24;

    state_t             state_q, state_d;
    logic [31:0]        a_op_q, a_op_d, b_op_q, b_op_d;
    logic               sub_q, sub_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [8:0]         exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic [SIG_W-1:0]   sig_a_q, sig_a_d, sig_b_q, sig_b_d;
    logic [31:0]        result_q, result_d;
    // Set when result_q already holds the final value (special or zero)
    // so PACK must leave it alone.
    logic               res_set_q, res_set_d;

    // ---------------- operand classification ----------------
    logic             ua_sign, ua_zero, ua_inf, ua_nan;
    logic             ub_sign, ub_zero, ub_inf, ub_nan;
    logic [EXP_W-1:0] ua_exp, ub_exp;
    logic [MAN_W-1:0] ua_man, ub_man;

    fp_unpack u_unpack_a (
        .op(a_op_q), .sign(ua_sign), .exp(ua_exp), .man(ua_man),
        .is_zero(ua_zero), .is_inf(ua_inf), .is_nan(ua_nan)
    );

    fp_unpack u_unpack_b (
        .op(b_op_q), .sign(ub_sign), .exp(ub_exp), .man(ub_man),
        .is_zero(ub_zero), .is_inf(ub_inf), .is_nan(ub_nan)
    );

    logic        eff_sb;
    logic        special;
    logic [31:0] special_val;

    always_comb begin
        eff_sb      = ub_sign ^ sub_q;
        special     = ua_nan | ub_nan | ua_inf | ub_inf | ua_zero | ub_zero;
        special_val = a_op_q;
        if (ua_nan || ub_nan || (ua_inf && ub_inf && (ua_sign != eff_sb)))
            special_val = QNAN;
        else if (ua_inf)
            special_val = POS_INF | {ua_sign, 31'd0};
        else if (ub_inf)
            special_val = POS_INF | {eff_sb, 31'd0};
        else if (ua_zero && ub_zero)
            special_val = 32'd0;
        else if (ua_zero)
            special_val = {eff_sb, b_op_q[30:0]};
    end

    // ---------------- datapath helpers ----------------
    logic [8:0]     exp_diff;
    logic           a_smaller, align_big, align_last;
    logic           a_ge_b;
    logic [SIG_W:0] sum_w;
    logic           sum_sign, sum_zero, sum_carry, sum_norm;
    logic           norm_uflow, norm_last;
    logic [31:0]    packed_val;

    always_comb begin
        a_smaller  = (exp_a_q < exp_b_q);
        exp_diff   = a_smaller ? (exp_b_q - exp_a_q) : (exp_a_q - exp_b_q);
        align_big  = (exp_diff > 9'(MAX_ALIGN));
        align_last = align_big || (exp_diff == 9'd1);

        // Exponents are equal here, so significands order the magnitudes.
        a_ge_b = (sig_a_q >= sig_b_q);
        if (sign_a_q == sign_b_q) begin
            sum_w    = {1'b0, sig_a_q} + {1'b0, sig_b_q};
            sum_sign = sign_a_q;
        end else if (a_ge_b) begin
            sum_w    = {1'b0, sig_a_q} - {1'b0, sig_b_q};
            sum_sign = sign_a_q;
        end else begin
            sum_w    = {1'b0, sig_b_q} - {1'b0, sig_a_q};
            sum_sign = sign_b_q;
        end
        sum_zero  = (sum_w == '0);
        sum_carry = sum_w[SIG_W];
        sum_norm  = sum_w[SIG_W-1];

        // One more left shift would take the exponent below 1.
        norm_uflow = (exp_a_q <= 9'd1);
        // The bit about to move into the hidden position is set.
        norm_last  = sig_a_q[SIG_W-2];

        if (exp_a_q >= 9'(EXP_MAX))
            packed_val = POS_INF | {sign_a_q, 31'd0};
        else
            packed_val = {sign_a_q, exp_a_q[7:0], sig_a_q[SIG_W-2 -: MAN_W]};
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.in_valid) state_d = ST_UNPACK;
            ST_UNPACK: begin
                if (special)               state_d = ST_PACK;
                else if (ua_exp == ub_exp) state_d = ST_ADD;
                else                       state_d = ST_ALIGN;
            end
            ST_ALIGN:  if (align_last) state_d = ST_ADD;
            ST_ADD: begin
                if (sum_zero || sum_carry || sum_norm) state_d = ST_PACK;
                else                                   state_d = ST_NORM;
            end
            ST_NORM:   if (norm_uflow || norm_last) state_d = ST_PACK;
            ST_PACK:   state_d = ST_DONE;
            ST_DONE:   if (bus.out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.Result    = result_q;
        dbg_state     = state_q;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        a_op_d    = a_op_q;
        b_op_d    = b_op_q;
        sub_d     = sub_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        exp_a_d   = exp_a_q;
        exp_b_d   = exp_b_q;
        sig_a_d   = sig_a_q;
        sig_b_d   = sig_b_q;
        result_d  = result_q;
        res_set_d = res_set_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_op_d = bus.A_in;
                    b_op_d = bus.B_in;
                    sub_d  = bus.A_S;
                end
            end
            ST_UNPACK: begin
                sign_a_d  = ua_sign;
                sign_b_d  = eff_sb;
                exp_a_d   = {1'b0, ua_exp};
                exp_b_d   = {1'b0, ub_exp};
                sig_a_d   = {1'b1, ua_man, {GRD_W{1'b0}}};
                sig_b_d   = {1'b1, ub_man, {GRD_W{1'b0}}};
                res_set_d = special;
                if (special) result_d = special_val;
            end
            ST_ALIGN: begin
                if (a_smaller) begin
                    sig_a_d = align_big ? '0 : (sig_a_q >> 1);
                    exp_a_d = align_big ? exp_b_q : (exp_a_q + 9'd1);
                end else begin
                    sig_b_d = align_big ? '0 : (sig_b_q >> 1);
                    exp_b_d = align_big ? exp_a_q : (exp_b_q + 9'd1);
                end
            end
            ST_ADD: begin
                // The sum lands in the A registers for NORM/PACK.
                sign_a_d = sum_sign;
                if (sum_zero) begin
                    result_d  = 32'd0;
                    res_set_d = 1'b1;
                end else if (sum_carry) begin
                    sig_a_d = sum_w[SIG_W:1];
                    exp_a_d = exp_a_q + 9'd1;
                end else begin
                    sig_a_d = sum_w[SIG_W-1:0];
                end
            end
            ST_NORM: begin
                if (norm_uflow) begin
                    result_d  = 32'd0;
                    res_set_d = 1'b1;
                end else begin
                    sig_a_d = sig_a_q << 1;
                    exp_a_d = exp_a_q - 9'd1;
                end
            end
            ST_PACK: begin
                if (!res_set_q) result_d = packed_val;
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_op_q    <= '0;
            b_op_q    <= '0;
            sub_q     <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            exp_a_q   <= '0;
            exp_b_q   <= '0;
            sig_a_q   <= '0;
            sig_b_q   <= '0;
            result_q  <= '0;
            res_set_q <= 1'b0;
        end else begin
            a_op_q    <= a_op_d;
            b_op_q    <= b_op_d;
            sub_q     <= sub_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            exp_a_q   <= exp_a_d;
            exp_b_q   <= exp_b_d;
            sig_a_q   <= sig_a_d;
            sig_b_q   <= sig_b_d;
            result_q  <= result_d;
            res_set_q <= res_set_d;
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_seq
// Directed bench for fp_addsub_seq: hand-computed results and latencies,
// output stall, ignored input while busy, and reset during alignment.
// ---------------------------------------------------------------------------
module tb_fp_addsub_seq;
    import fp_pkg::*;

    localparam logic [31:0] ONE = {1'b0, 8'(BIAS), 23'd0};  // 1.0

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_assert;
    int     n_fail;

    fp_addsub_seq_if bus ();

    fp_addsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Present an operand pair, step through the accept edge, then scramble
    // the inputs to show they are no longer sampled.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic early_rdy, input string tag);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.A_in      = a;
        bus.B_in      = b;
        bus.A_S       = s;
        bus.out_ready = early_rdy;
        check32({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A_in     = 32'h12345678;
        bus.B_in     = 32'h9ABCDEF0;
        bus.A_S      = ~s;
        check32({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_valid(input logic [31:0] exp_res, input int exp_lat, input string tag);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check32({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check32({tag, "_result"}, bus.Result, exp_res);
    endtask

    // Take the result; the unit must be idle right after the handshake edge.
    task automatic finish_op(input string tag);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check32({tag, "_idle_after"}, 32'(bus.in_ready), 32'd1);
        check32({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        start_op(a, b, s, 1'b0, tag);
        wait_valid(exp_res, exp_lat, tag);
        finish_op(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A_in      = '0;
        bus.B_in      = '0;
        bus.A_S       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check32("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check32("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check32("reset_result",    bus.Result,         32'd0);
        check32("reset_state",     32'(dbg_state),     32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // Main arithmetic: carry, cancellation, sign handling.
        run_op(32'h40966666, 32'h40C66666, 1'b0, 32'h412E6666, 3, "add_carry");
        run_op(32'h40966666, 32'h40C66666, 1'b1, 32'hBFC00000, 5, "sub_norm2");
        run_op(32'h40966666, 32'hC0C66666, 1'b1, 32'h412E6666, 3, "sub_negb");
        run_op(32'hC0966666, 32'h40C66666, 1'b0, 32'h3FC00000, 5, "add_nega");
        run_op(ONE,          ONE,          1'b1, 32'h00000000, 3, "exact_zero");

        // Specials: 2-cycle path.
        run_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2, "inf_minus_inf");
        run_op(32'h7F800001, ONE,          1'b0, 32'h7FC00000, 2, "nan_in");
        run_op(32'h7F800000, ONE,          1'b0, 32'h7F800000, 2, "inf_a");
        run_op(ONE,          32'h7F800000, 1'b1, 32'hFF800000, 2, "inf_b_sub");
        run_op(32'h00000001, ONE,          1'b0, ONE,          2, "denorm_flush");

        // Alignment boundaries and rounding toward zero.
        run_op(32'h4C000000, ONE,          1'b0, 32'h4C000000, 28, "align_25");
        run_op(32'h4D800000, ONE,          1'b0, 32'h4D800000, 4,  "align_cap");
        run_op(ONE,          32'h33800000, 1'b0, ONE,          27, "trunc_guard");

        // Exponent overflow and underflow.
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3, "overflow");
        run_op(32'h00800000, 32'h00800001, 1'b1, 32'h00000000, 4, "underflow");

        // out_ready high early must not shorten latency.
        start_op(32'h40966666, 32'h40C66666, 1'b0, 1'b1, "early_rdy");
        wait_valid(32'h412E6666, 3, "early_rdy");
        finish_op("early_rdy");

        // Stall the consumer for 10 cycles while pushing new operands.
        start_op(32'h40966666, 32'h40C66666, 1'b1, 1'b0, "stall");
        wait_valid(32'hBFC00000, 5, "stall");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.A_in     = 32'(($urandom_range(255) << 23) | $urandom_range(8388607));
            bus.B_in     = ONE;
            bus.A_S      = 1'b0;
            @(posedge clk);
            #1;
            check32("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check32("stall_result",    bus.Result,         32'hBFC00000);
            check32("stall_in_ready",  32'(bus.in_ready),  32'd0);
        end
        finish_op("stall");
        run_op(ONE, ONE, 1'b0, 32'h40000000, 3, "after_stall");

        // Reset in the middle of a 23-cycle alignment.
        start_op(32'h4B000000, ONE, 1'b0, 1'b0, "rst_mid");
        repeat (5) @(posedge clk);
        #1;
        check32("rst_mid_in_align", 32'(dbg_state), 32'(ST_ALIGN));
        rst = 1'b1;
        #1;
        check32("rst_mid_in_ready",  32'(bus.in_ready),  32'd1);
        check32("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check32("rst_mid_result",    bus.Result,         32'd0);
        check32("rst_mid_state",     32'(dbg_state),     32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h4B000000, ONE, 1'b0, 32'h4B000001, 26, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
